// File: rtl/arbiter_wrr_n.sv
// N-way weighted round-robin arbiter feeding a registered valid/ready output slice.
// Define ARB_WRR_PKT_LOCK_EN to add in_last and keep the grant for whole multi-beat packets.
module arbiter_wrr_n #(
   parameter int  DWIDTH = 16,
   parameter int  N      = 4,
   parameter int  WWIDTH = 4,
   localparam int SWIDTH = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid  [N],
   input  logic [DWIDTH-1:0] in_data   [N],
   output logic              in_ready  [N],
   input  logic [WWIDTH-1:0] in_weight [N],
`ifdef ARB_WRR_PKT_LOCK_EN
   input  logic              in_last   [N],
`endif
   output logic              out_valid,
   output logic [DWIDTH-1:0] out_data,
   output logic [SWIDTH-1:0] out_src,
   input  logic              out_ready
);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t              state;
   logic [SWIDTH-1:0]   ptr;
   logic [SWIDTH-1:0]   owner;
   logic [WWIDTH-1:0]   cnt;
   logic [WWIDTH-1:0]   wlat;
`ifdef ARB_WRR_PKT_LOCK_EN
   logic                mid_pkt;
`endif

   logic                load;
   logic                owner_valid;
   logic                forfeit;
   logic                hold_owner;
   logic [SWIDTH-1:0]   start;
   logic [SWIDTH-1:0]   idx;
   logic [SWIDTH-1:0]   sel;
   logic                found;
   logic                gnt_valid;
   logic [SWIDTH-1:0]   gnt_idx;
   logic                xfer;
   logic [WWIDTH-1:0]   eff_w;

   function automatic logic [SWIDTH-1:0] nxt(input logic [SWIDTH-1:0] i);
      return (i == SWIDTH'(N - 1)) ? '0 : i + SWIDTH'(1);
   endfunction

   // A SERVE tenure is forfeited when its owner goes idle; mid-packet gaps are locked instead.
   always_comb begin
      load        = !out_valid || out_ready;
      owner_valid = in_valid[owner];
`ifdef ARB_WRR_PKT_LOCK_EN
      forfeit     = (state == SERVE) && !owner_valid && !mid_pkt;
`else
      forfeit     = (state == SERVE) && !owner_valid;
`endif
      hold_owner  = (state == SERVE) && !forfeit;
      start       = forfeit ? nxt(owner) : ptr;
      found       = 1'b0;
      sel         = '0;
      idx         = start;
      for (int k = 0; k < N; k++) begin
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
         idx = nxt(idx);
      end
      gnt_valid = hold_owner ? owner_valid : found;
      gnt_idx   = hold_owner ? owner : sel;
      xfer      = gnt_valid && load;
      eff_w     = (in_weight[gnt_idx] == '0) ? WWIDTH'(1) : in_weight[gnt_idx];
      for (int i = 0; i < N; i++) begin
         in_ready[i] = xfer && (gnt_idx == SWIDTH'(i));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         state     <= IDLE;
         ptr       <= '0;
         owner     <= '0;
         cnt       <= '0;
         wlat      <= '0;
`ifdef ARB_WRR_PKT_LOCK_EN
         mid_pkt   <= 1'b0;
`endif
      end else begin
         if (load) begin
            out_valid <= xfer;
            if (xfer) begin
               out_data <= in_data[gnt_idx];
               out_src  <= gnt_idx;
            end
         end
         if (forfeit) begin
            state <= IDLE;
            ptr   <= nxt(owner);
            cnt   <= '0;
         end
         // A transfer while not holding an owner opens a new tenure and latches its weight.
         if (xfer && !hold_owner) begin
            owner <= gnt_idx;
            wlat  <= eff_w;
`ifdef ARB_WRR_PKT_LOCK_EN
            mid_pkt <= !in_last[gnt_idx];
            if (in_last[gnt_idx] && (eff_w == WWIDTH'(1))) begin
               state <= IDLE;
               ptr   <= nxt(gnt_idx);
               cnt   <= WWIDTH'(1);
            end else begin
               state <= SERVE;
               cnt   <= in_last[gnt_idx] ? WWIDTH'(1) : '0;
            end
`else
            cnt <= WWIDTH'(1);
            if (eff_w == WWIDTH'(1)) begin
               state <= IDLE;
               ptr   <= nxt(gnt_idx);
            end else begin
               state <= SERVE;
            end
`endif
         end else if (xfer) begin
`ifdef ARB_WRR_PKT_LOCK_EN
            mid_pkt <= !in_last[owner];
            if (in_last[owner]) begin
               if (cnt + WWIDTH'(1) == wlat) begin
                  state <= IDLE;
                  ptr   <= nxt(owner);
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + WWIDTH'(1);
               end
            end
`else
            if (cnt + WWIDTH'(1) == wlat) begin
               state <= IDLE;
               ptr   <= nxt(owner);
               cnt   <= '0;
            end else begin
               cnt <= cnt + WWIDTH'(1);
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_arbiter_wrr_n.sv
// Directed bench for arbiter_wrr_n (N=4): reset, rotation, weights, forfeit, stall and packet lock.
// Inputs change on the falling edge; registered outputs are checked on the falling edge too.
module tb_arbiter_wrr_n;

   logic        clk;
   logic        rst;
   logic        in_valid  [4];
   logic [15:0] in_data   [4];
   logic        in_ready  [4];
   logic [3:0]  in_weight [4];
`ifdef ARB_WRR_PKT_LOCK_EN
   logic        in_last   [4];
`endif
   logic        out_valid;
   logic [15:0] out_data;
   logic [1:0]  out_src;
   logic        out_ready;
   logic [3:0]  rdy_vec;

   int vectors    = 0;
   int miscompares = 0;

   int rr_exp     [5]  = '{0, 1, 2, 3, 0};
   int wrr_exp    [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
   int forfeit_exp[8]  = '{0, 0, 1, 2, 3, 0, 0, 0};

   arbiter_wrr_n #(.DWIDTH(16), .N(4), .WWIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .in_weight (in_weight),
`ifdef ARB_WRR_PKT_LOCK_EN
      .in_last   (in_last),
`endif
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   always_comb rdy_vec = {in_ready[3], in_ready[2], in_ready[1], in_ready[0]};

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] vmask, input logic ready);
      for (int i = 0; i < 4; i++) in_valid[i] = vmask[i];
      out_ready = ready;
   endtask

   task automatic setWeights(input logic [3:0] w0, input logic [3:0] w1,
                             input logic [3:0] w2, input logic [3:0] w3);
      in_weight[0] = w0;
      in_weight[1] = w1;
      in_weight[2] = w2;
      in_weight[3] = w3;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clk = 1'b0;
      rst = 1'b0;
      applyStimulus(4'b0000, 1'b0);
      for (int i = 0; i < 4; i++) in_data[i] = 16'hA000 + 16'(i);
      setWeights(4'd1, 4'd1, 4'd1, 4'd1);
`ifdef ARB_WRR_PKT_LOCK_EN
      for (int i = 0; i < 4; i++) in_last[i] = 1'b1;
`endif

      #2;
      checkOutput("por_valid", 32'(out_valid), 32'd0);
      checkOutput("por_data",  32'(out_data),  32'd0);
      checkOutput("por_src",   32'(out_src),   32'd0);

      // Load 0xBEEF from ch3, stall it, then reset asynchronously mid-cycle.
      @(negedge clk);
      rst        = 1'b1;
      in_data[3] = 16'hBEEF;
      applyStimulus(4'b1000, 1'b0);
      @(negedge clk);
      checkOutput("beef_valid", 32'(out_valid), 32'd1);
      checkOutput("beef_data",  32'(out_data),  32'hBEEF);
      checkOutput("beef_src",   32'(out_src),   32'd3);
      checkOutput("full_rdy",   32'(rdy_vec),   32'h0);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("async_rst_data",  32'(out_data),  32'd0);
      checkOutput("async_rst_src",   32'(out_src),   32'd0);

      // Plain rotation with unit weights.
      @(negedge clk);
      rst        = 1'b1;
      in_data[3] = 16'hA003;
      applyStimulus(4'b1111, 1'b1);
      #1;
      checkOutput("rr_first_rdy", 32'(rdy_vec), 32'h1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("rr_valid", 32'(out_valid), 32'd1);
         checkOutput("rr_src",   32'(out_src),   32'(rr_exp[k]));
         checkOutput("rr_data",  32'(out_data),  32'hA000 + 32'(rr_exp[k]));
      end

      // Weights {3,1,2,0}; zero weight behaves as one.
      doReset();
      setWeights(4'd3, 4'd1, 4'd2, 4'd0);
      applyStimulus(4'b1111, 1'b1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checkOutput("wrr_valid", 32'(out_valid), 32'd1);
         checkOutput("wrr_src",   32'(out_src),   32'(wrr_exp[k]));
      end

      // ch0 (weight 4) goes idle after 2 beats and loses the rest of its tenure.
      doReset();
      setWeights(4'd4, 4'd1, 4'd1, 4'd1);
      applyStimulus(4'b1111, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput("forfeit_src", 32'(out_src), 32'(forfeit_exp[k]));
         if (k == 1) begin
            in_valid[0] = 1'b0;
            #1;
            checkOutput("forfeit_rdy", 32'(rdy_vec), 32'h2);
         end
         if (k == 2) in_valid[0] = 1'b1;
      end

      // Downstream stall with only ch2 (weight 2) requesting.
      doReset();
      setWeights(4'd1, 4'd1, 4'd2, 4'd1);
      applyStimulus(4'b0100, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("stall_valid", 32'(out_valid), 32'd1);
         checkOutput("stall_data",  32'(out_data),  32'hA002);
         checkOutput("stall_rdy",   32'(rdy_vec),   32'h0);
         if (k == 0) in_data[2] = 16'hA0F2;
      end
      out_ready = 1'b1;
      #1;
      checkOutput("release_rdy", 32'(rdy_vec), 32'h4);
      @(negedge clk);
      checkOutput("release_valid", 32'(out_valid), 32'd1);
      checkOutput("release_data",  32'(out_data),  32'hA0F2);
      checkOutput("release_src",   32'(out_src),   32'd2);
      applyStimulus(4'b1100, 1'b1);
      @(negedge clk);
      checkOutput("rotate_valid", 32'(out_valid), 32'd1);
      checkOutput("rotate_src",   32'(out_src),   32'd3);
      checkOutput("rotate_data",  32'(out_data),  32'hA003);
      in_data[2] = 16'hA002;

`ifdef ARB_WRR_PKT_LOCK_EN
      // ch1 sends a 3-beat packet with a 2-cycle gap while ch0 waits.
      doReset();
      setWeights(4'd1, 4'd1, 4'd1, 4'd1);
      in_last[1] = 1'b0;
      applyStimulus(4'b0010, 1'b1);
      @(negedge clk);
      checkOutput("pkt_b1_src", 32'(out_src), 32'd1);
      applyStimulus(4'b0011, 1'b1);
      #1;
      checkOutput("pkt_b2_rdy", 32'(rdy_vec), 32'h2);
      @(negedge clk);
      applyStimulus(4'b0001, 1'b1);
      #1;
      checkOutput("pkt_gap1_rdy", 32'(rdy_vec), 32'h0);
      @(negedge clk);
      checkOutput("pkt_gap_valid", 32'(out_valid), 32'd0);
      checkOutput("pkt_gap2_rdy",  32'(rdy_vec),   32'h0);
      @(negedge clk);
      in_last[1] = 1'b1;
      applyStimulus(4'b0011, 1'b1);
      #1;
      checkOutput("pkt_last_rdy", 32'(rdy_vec), 32'h2);
      @(negedge clk);
      checkOutput("pkt_last_valid", 32'(out_valid), 32'd1);
      checkOutput("pkt_last_src",   32'(out_src),   32'd1);
      applyStimulus(4'b0001, 1'b1);
      #1;
      checkOutput("pkt_after_rdy", 32'(rdy_vec), 32'h1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
